led_matrix_scan: RTL and testbench

//   Parametrised column-scanning driver for an N_COLS x N_ROWS LED matrix.

---
 rtl/led_matrix_pkg.sv | 89 ++++++++
 rtl/led_scan_timer.sv | 94 +++++++++
 rtl/led_matrix_scan.sv | 158 +++++++++++++++
 tb/tb_led_matrix_scan.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// ---------------------------------------------------------------------------
// led_matrix_pkg
// Shared definitions for the LED matrix column scanner:
//   - glyph codes (GLYPH_BLANK .. GLYPH_ZERO)
//   - default panel geometry (5 columns x 7 rows)
//   - scan FSM state encoding
//   - idx_w(): safe index width for a count (minimum 1 bit)
//   - glyph_col(): the glyph ROM, returning one column pattern (row[0] = top)
// ---------------------------------------------------------------------------
package led_matrix_pkg;

  // Glyph codes
  localparam int unsigned GLYPH_BLANK = 0;
  localparam int unsigned GLYPH_LOW   = 1;
  localparam int unsigned GLYPH_MID   = 2;
  localparam int unsigned GLYPH_HIGH  = 3;
  localparam int unsigned GLYPH_ERROR = 4;
  localparam int unsigned GLYPH_A     = 5;
  localparam int unsigned GLYPH_G     = 6;
  localparam int unsigned GLYPH_ZERO  = 7;

  // Default panel geometry
  localparam int unsigned DEFAULT_N_COLS = 5;
  localparam int unsigned DEFAULT_N_ROWS = 7;

  // Font geometry: glyphs are 5 columns wide, wider panels repeat them
  localparam int unsigned FONT_COLS = 5;
  // Widest row vector glyph_col() can return
  localparam int unsigned ROW_MAX   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_t;

  // Width needed to index n items; never less than 1 bit
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Glyph ROM: column 'idx' of glyph 'code'. Unknown codes show ERROR.
  function automatic logic [ROW_MAX-1:0] glyph_col(input int unsigned code,
                                                   input int unsigned idx);
    logic [6:0]  pat;
    int unsigned c;
    c   = idx % FONT_COLS;
    pat = 7'h00;
    case (code)
      GLYPH_BLANK: pat = 7'h00;
      GLYPH_LOW:   pat = 7'h3F;
      GLYPH_MID:   pat = 7'h1F;
      GLYPH_HIGH:  pat = 7'h7F;
      GLYPH_A: begin
        case (c)
          0, 4:    pat = 7'h7E;
          default: pat = 7'h09;
        endcase
      end
      GLYPH_G: begin
        case (c)
          0:       pat = 7'h3E;
          1:       pat = 7'h41;
          2, 3:    pat = 7'h49;
          default: pat = 7'h3A;
        endcase
      end
      GLYPH_ZERO: begin
        case (c)
          0:       pat = 7'h3E;
          1:       pat = 7'h51;
          2:       pat = 7'h49;
          3:       pat = 7'h45;
          default: pat = 7'h3E;
        endcase
      end
      default: begin
        // GLYPH_ERROR and any out-of-range code: letter 'E'
        case (c)
          0:       pat = 7'h7F;
          4:       pat = 7'h41;
          default: pat = 7'h49;
        endcase
      end
    endcase
    return ROW_MAX'(pat);
  endfunction

endpackage

// File: rtl/led_scan_timer.sv
// ---------------------------------------------------------------------------
// led_scan_timer
// Column slot timer for the LED matrix scanner. Each slot is DIV_TICKS cycles:
// BLANK_TICKS blank cycles followed by the drive phase. Columns advance at the
// end of each slot; after the last column it wraps and pulses o_wrap.
//
// Ports:
//   clk        in   system clock, rising edge
//   rstn       in   asynchronous reset, active-HIGH
//   i_run      in   1 = scan, 0 = return to idle on the next edge
//   o_idle     out  timer is idle (from state register)
//   o_drive    out  current slot is in its drive phase (from state register)
//   o_col_idx  out  current column index
//   o_wrap     out  registered pulse: the last column's slot just ended
// ---------------------------------------------------------------------------
module led_scan_timer
  import led_matrix_pkg::*;
#(
  parameter int unsigned N_COLS      = DEFAULT_N_COLS,
  parameter int unsigned DIV_TICKS   = 1000,
  parameter int unsigned BLANK_TICKS = 2
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        i_run,
  output logic                        o_idle,
  output logic                        o_drive,
  output logic [idx_w(N_COLS)-1:0]    o_col_idx,
  output logic                        o_wrap
);

  localparam int unsigned TW = idx_w(DIV_TICKS);
  localparam int unsigned CW = idx_w(N_COLS);

  localparam logic [TW-1:0] TICK_LAST  = TW'(DIV_TICKS - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK_TICKS == 0) ? 0 : BLANK_TICKS - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(N_COLS - 1);

  // With no blanking a slot starts directly in its drive phase
  localparam scan_state_t SLOT_START = (BLANK_TICKS == 0) ? ST_DRIVE : ST_BLANK;

  scan_state_t   r_state;
  logic [TW-1:0] r_tick;
  logic [CW-1:0] r_col_idx;
  logic          r_wrap;

  // Slot sequencing: IDLE -> (BLANK ->) DRIVE per column, wrapping per frame
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_state   <= ST_IDLE;
      r_tick    <= '0;
      r_col_idx <= '0;
      r_wrap    <= 1'b0;
    end else if (!i_run) begin
      r_state   <= ST_IDLE;
      r_tick    <= '0;
      r_col_idx <= '0;
      r_wrap    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state   <= SLOT_START;
          r_tick    <= '0;
          r_col_idx <= '0;
          r_wrap    <= 1'b0;
        end
        default: begin
          r_wrap <= 1'b0;
          if (r_tick == TICK_LAST) begin
            r_tick  <= '0;
            r_state <= SLOT_START;
            if (r_col_idx == COL_LAST) begin
              r_col_idx <= '0;
              r_wrap    <= 1'b1;
            end else begin
              r_col_idx <= r_col_idx + CW'(1);
            end
          end else begin
            r_tick <= r_tick + TW'(1);
            if (r_state == ST_BLANK && r_tick == BLANK_LAST) begin
              r_state <= ST_DRIVE;
            end
          end
        end
      endcase
    end
  end

  assign o_idle    = (r_state == ST_IDLE);
  assign o_drive   = (r_state == ST_DRIVE);
  assign o_col_idx = r_col_idx;
  assign o_wrap    = r_wrap;

endmodule

// File: rtl/led_matrix_scan.sv
// ---------------------------------------------------------------------------
// led_matrix_scan
// Parametrised column-scanning driver for an N_COLS x N_ROWS LED matrix.
// Looks up the latched glyph in the shared ROM, drives one column at a time
// with anti-ghost blanking between columns, and swaps glyphs only at frame
// boundaries. Outputs lag the slot timer by one register stage, so the first
// column lights BLANK_TICKS+1 cycles after enable is sampled in idle.
//
// Optional feature (compile-time macro LED_MATRIX_BLINK_EN):
//   frame-counted blinking; while blink=1 the rows are blanked for alternating
//   blocks of BLINK_FRAMES frames, starting at the first frame boundary.
//   Without the macro, blink is ignored.
//
// Ports:
//   clk           in   system clock, rising edge
//   rstn          in   asynchronous reset, active-HIGH
//   en            in   scan enable
//   glyph_sel     in   requested glyph code
//   blink         in   blink request
//   col           out  one-hot column drive, active-high
//   row           out  row drive for the current column (row[0] = top)
//   col_idx       out  index of the column being driven
//   glyph_active  out  glyph code currently displayed
//   frame_done    out  1-cycle pulse at each frame boundary
// ---------------------------------------------------------------------------
module led_matrix_scan
  import led_matrix_pkg::*;
#(
  parameter int unsigned N_COLS       = DEFAULT_N_COLS,
  parameter int unsigned N_ROWS       = DEFAULT_N_ROWS,
  parameter int unsigned DIV_TICKS    = 1000,
  parameter int unsigned BLANK_TICKS  = 2,
  parameter int unsigned GLYPH_W      = 3,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      en,
  input  logic [GLYPH_W-1:0]        glyph_sel,
  input  logic                      blink,
  output logic [N_COLS-1:0]         col,
  output logic [N_ROWS-1:0]         row,
  output logic [idx_w(N_COLS)-1:0]  col_idx,
  output logic [GLYPH_W-1:0]        glyph_active,
  output logic                      frame_done
);

  localparam int unsigned CW = idx_w(N_COLS);

  logic               w_idle;
  logic               w_drive;
  logic               w_wrap;
  logic [CW-1:0]      w_col_idx;
  logic [GLYPH_W-1:0] w_glyph_next;
  logic [N_ROWS-1:0]  w_rom_row;
  logic               w_row_gate;

  logic [N_COLS-1:0]  r_col;
  logic [N_ROWS-1:0]  r_row;
  logic [CW-1:0]      r_col_idx;
  logic [GLYPH_W-1:0] r_glyph_active;
  logic               r_frame_done;

  led_scan_timer #(
    .N_COLS      (N_COLS),
    .DIV_TICKS   (DIV_TICKS),
    .BLANK_TICKS (BLANK_TICKS)
  ) u_timer (
    .clk       (clk),
    .rstn      (rstn),
    .i_run     (en),
    .o_idle    (w_idle),
    .o_drive   (w_drive),
    .o_col_idx (w_col_idx),
    .o_wrap    (w_wrap)
  );

  // The first column of a new frame already shows the glyph being latched
  assign w_glyph_next = w_wrap ? glyph_sel : r_glyph_active;
  assign w_rom_row    = N_ROWS'(glyph_col(32'(w_glyph_next), 32'(w_col_idx)));

`ifdef LED_MATRIX_BLINK_EN
  localparam int unsigned BW = idx_w(2 * BLINK_FRAMES);

  logic [BW-1:0] r_blink_cnt;
  logic [BW-1:0] w_blink_cnt_nxt;
  logic          r_blink_seen;
  logic          w_blink_seen_nxt;

  // Frame count since blink rose; the first boundary starts the off phase
  always_comb begin
    w_blink_cnt_nxt  = r_blink_cnt;
    w_blink_seen_nxt = r_blink_seen;
    if (!en || !blink) begin
      w_blink_cnt_nxt  = '0;
      w_blink_seen_nxt = 1'b0;
    end else if (w_wrap) begin
      if (!r_blink_seen) begin
        w_blink_seen_nxt = 1'b1;
        w_blink_cnt_nxt  = '0;
      end else if (r_blink_cnt == BW'(2 * BLINK_FRAMES - 1)) begin
        w_blink_cnt_nxt = '0;
      end else begin
        w_blink_cnt_nxt = r_blink_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_blink_cnt  <= '0;
      r_blink_seen <= 1'b0;
    end else begin
      r_blink_cnt  <= w_blink_cnt_nxt;
      r_blink_seen <= w_blink_seen_nxt;
    end
  end

  // Off during the first BLINK_FRAMES of every 2*BLINK_FRAMES block
  assign w_row_gate = blink && w_blink_seen_nxt &&
                      (w_blink_cnt_nxt < BW'(BLINK_FRAMES));
`else
  logic [1:0] w_unused_blink;
  assign w_unused_blink = {blink, 1'(BLINK_FRAMES % 2)};
  assign w_row_gate     = 1'b0;
`endif

  // Output registers; en=0 forces the pins dark on the next edge
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_col          <= '0;
      r_row          <= '0;
      r_col_idx      <= '0;
      r_glyph_active <= '0;
      r_frame_done   <= 1'b0;
    end else if (!en) begin
      r_col        <= '0;
      r_row        <= '0;
      r_col_idx    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      r_col_idx    <= w_col_idx;
      if (w_idle || w_wrap) begin
        r_glyph_active <= glyph_sel;
      end
      r_col <= w_drive ? (N_COLS'(1) << w_col_idx) : '0;
      r_row <= (w_drive && !w_row_gate) ? w_rom_row : '0;
    end
  end

  assign col          = r_col;
  assign row          = r_row;
  assign col_idx      = r_col_idx;
  assign glyph_active = r_glyph_active;
  assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_led_matrix_scan.sv
// ---------------------------------------------------------------------------
// tb_led_matrix_scan
// Two scanner instances: A = 5x7, DIV_TICKS=10, BLANK_TICKS=2, BLINK_FRAMES=2;
// B = 8x8, DIV_TICKS=3, BLANK_TICKS=0, GLYPH_W=4. Outputs are predicted from
// the time elapsed since the scan started (k = edges since enable was taken).
// ---------------------------------------------------------------------------
module tb_led_matrix_scan;

  localparam int BLINK_F = 2;

  // Glyph bitmaps, column 0 in the low 7 bits
  localparam logic [34:0] FONT [8] = '{
    35'h0,
    {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F},
    {7'h1F, 7'h1F, 7'h1F, 7'h1F, 7'h1F},
    {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F},
    {7'h41, 7'h49, 7'h49, 7'h49, 7'h7F},
    {7'h7E, 7'h09, 7'h09, 7'h09, 7'h7E},
    {7'h3A, 7'h49, 7'h49, 7'h41, 7'h3E},
    {7'h3E, 7'h45, 7'h49, 7'h51, 7'h3E}
  };

  logic       clk;
  logic       rst;
  logic       en_a, en_b, bl_a, bl_b;
  logic [2:0] g_a;
  logic [3:0] g_b;
  logic [4:0] col_a;
  logic [6:0] row_a;
  logic [2:0] idx_a, ga_a;
  logic       fd_a;
  logic [7:0] col_b, row_b;
  logic [2:0] idx_b;
  logic [3:0] ga_b;
  logic       fd_b;

  int n_checks = 0;
  int n_errors = 0;
  int cur;

  led_matrix_scan #(.N_COLS(5), .N_ROWS(7), .DIV_TICKS(10), .BLANK_TICKS(2),
                    .GLYPH_W(3), .BLINK_FRAMES(BLINK_F)) dut_a (
    .clk(clk), .rstn(rst), .en(en_a), .glyph_sel(g_a), .blink(bl_a),
    .col(col_a), .row(row_a), .col_idx(idx_a), .glyph_active(ga_a),
    .frame_done(fd_a));

  led_matrix_scan #(.N_COLS(8), .N_ROWS(8), .DIV_TICKS(3), .BLANK_TICKS(0),
                    .GLYPH_W(4), .BLINK_FRAMES(BLINK_F)) dut_b (
    .clk(clk), .rstn(rst), .en(en_b), .glyph_sel(g_b), .blink(bl_b),
    .col(col_b), .row(row_b), .col_idx(idx_b), .glyph_active(ga_b),
    .frame_done(fd_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int font_col(input int code, input int c);
    logic [34:0] bm;
    bm = FONT[(code > 7) ? 4 : code];
    return int'(bm[c*7 +: 7]);
  endfunction

  // Expected outputs k edges after the scan started
  function automatic void model_out(input bit run, input int k, input int g,
                                    input bit gate, input int n, input int div,
                                    input int b, output int e_col, output int e_row,
                                    output int e_idx, output int e_fd);
    int m, slot, pos;
    e_col = 0; e_row = 0; e_idx = 0; e_fd = 0;
    if (run && k > 0) begin
      m     = k - 1;
      slot  = (m / div) % n;
      pos   = m % div;
      e_idx = slot;
      e_fd  = (m > 0 && (m % (n * div)) == 0) ? 1 : 0;
      if (pos >= b) begin
        e_col = 1 << slot;
        if (!gate) e_row = font_col(g, slot % 5);
      end
    end
  endfunction

  function automatic bit blink_off(input bit bl, input int bf);
`ifdef LED_MATRIX_BLINK_EN
    return bl && bf > 0 && (((bf - 1) / BLINK_F) % 2 == 0);
`else
    return 1'b0;
`endif
  endfunction

  // Model state
  bit ma_run, mb_run;
  int ma_k, mb_k, ma_g, mb_g, ma_bf, mb_bf;

  always @(posedge clk) begin : cmp
    int ec, er, ei, ef, fc, fr, fi, ff;
    bit bnd;
    if (rst) begin
      ma_run = 0; ma_k = 0; ma_g = 0; ma_bf = 0;
      mb_run = 0; mb_k = 0; mb_g = 0; mb_bf = 0;
    end else begin
      if (!en_a) begin
        ma_run = 0; ma_k = 0; ma_bf = 0;
      end else if (!ma_run) begin
        ma_run = 1; ma_k = 0; ma_g = int'(g_a);
        if (!bl_a) ma_bf = 0;
      end else begin
        ma_k++;
        bnd = (ma_k > 1) && (((ma_k - 1) % 50) == 0);
        if (bnd) ma_g = int'(g_a);
        if (!bl_a) ma_bf = 0; else if (bnd) ma_bf++;
      end
      if (!en_b) begin
        mb_run = 0; mb_k = 0; mb_bf = 0;
      end else if (!mb_run) begin
        mb_run = 1; mb_k = 0; mb_g = int'(g_b);
        if (!bl_b) mb_bf = 0;
      end else begin
        mb_k++;
        bnd = (mb_k > 1) && (((mb_k - 1) % 24) == 0);
        if (bnd) mb_g = int'(g_b);
        if (!bl_b) mb_bf = 0; else if (bnd) mb_bf++;
      end
    end
    model_out(ma_run, ma_k, ma_g, blink_off(bl_a, ma_bf), 5, 10, 2, ec, er, ei, ef);
    model_out(mb_run, mb_k, mb_g, blink_off(bl_b, mb_bf), 8, 3, 0, fc, fr, fi, ff);
    #1;
    n_checks++;
    if (int'(col_a) != ec || int'(row_a) != er || int'(idx_a) != ei ||
        int'(fd_a) != ef || int'(ga_a) != ma_g) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL scan_a k=%0d col=%0h/%0h row=%0h/%0h idx=%0d/%0d fd=%0d/%0d glyph=%0d/%0d (got/exp)",
                 ma_k, col_a, ec, row_a, er, idx_a, ei, fd_a, ef, ga_a, ma_g);
    end
    n_checks++;
    if (int'(col_b) != fc || int'(row_b) != fr || int'(idx_b) != fi ||
        int'(fd_b) != ff || int'(ga_b) != mb_g) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL scan_b k=%0d col=%0h/%0h row=%0h/%0h idx=%0d/%0d fd=%0d/%0d glyph=%0d/%0d (got/exp)",
                 mb_k, col_b, fc, row_b, fr, idx_b, fi, fd_b, ff, ga_b, mb_g);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic goto(input int k);
    while (cur < k) begin
      @(negedge clk);
      cur++;
    end
  endtask

  initial begin
    int blk_row;
`ifdef LED_MATRIX_BLINK_EN
    blk_row = 0;
`else
    blk_row = 'h7F;
`endif
    rst = 1; en_a = 0; en_b = 0; bl_a = 0; bl_b = 0; g_a = 0; g_b = 0;
    repeat (3) @(negedge clk);
    chk("reset_col", int'(col_a), 0);
    chk("reset_row", int'(row_a), 0);
    chk("reset_glyph", int'(ga_a), 0);
    rst = 0;
    @(negedge clk);

    // Scan timing with glyph LOW
    g_a = 3'd1; en_a = 1; cur = -1;
    goto(2);   chk("latency_dark", int'(col_a), 0);
    goto(3);   chk("first_col", int'(col_a), 'h01);
               chk("first_row", int'(row_a), 'h3F);
    goto(10);  chk("col0_last", int'(col_a), 'h01);
    goto(11);  chk("blank_gap", int'(col_a), 0);
               chk("idx_adv", int'(idx_a), 1);
    goto(13);  chk("col1", int'(col_a), 'h02);
    goto(50);  chk("fd_before", int'(fd_a), 0);
    goto(51);  chk("fd_pulse", int'(fd_a), 1);
               chk("fd_idx", int'(idx_a), 0);
    goto(52);  chk("fd_after", int'(fd_a), 0);

    // Glyph swap mid-frame
    goto(75);  g_a = 3'd4;
    goto(78);  chk("swap_hold_row", int'(row_a), 'h3F);
    goto(100); chk("swap_hold_glyph", int'(ga_a), 1);
    goto(101); chk("swap_fd", int'(fd_a), 1);
               chk("swap_glyph", int'(ga_a), 4);
    goto(103); chk("err_col0", int'(row_a), 'h7F);
    goto(113); chk("err_col1", int'(row_a), 'h49);

    // Enable drop at column 3
    goto(135); chk("drop_idx3", int'(idx_a), 3);
    en_a = 0;
    goto(136); chk("drop_col", int'(col_a), 0);
               chk("drop_idx", int'(idx_a), 0);
    goto(140);
    en_a = 1; cur = -1;
    goto(2);   chk("reen_dark", int'(col_a), 0);
    goto(3);   chk("reen_col", int'(col_a), 'h01);
               chk("reen_row", int'(row_a), 'h7F);

    // Blink request
    goto(10);  bl_a = 1;
    goto(13);  chk("blink_pre", int'(row_a), 'h49);
    goto(53);  chk("blink_f1_row", int'(row_a), blk_row);
               chk("blink_f1_col", int'(col_a), 'h01);
    goto(153); chk("blink_f3_row", int'(row_a), 'h7F);
    goto(253); chk("blink_f5_row", int'(row_a), blk_row);
    bl_a = 0;
    goto(256); chk("blink_clear", int'(row_a), 'h7F);

    // Asynchronous reset mid-drive
    rst = 1;
    #1;
    chk("rst_col", int'(col_a), 0);
    chk("rst_row", int'(row_a), 0);
    chk("rst_glyph", int'(ga_a), 0);
    @(negedge clk);
    rst = 0; cur = -1;
    goto(2);   chk("rst_restart_dark", int'(col_a), 0);
    goto(3);   chk("rst_restart_col", int'(col_a), 'h01);
    en_a = 0;

    // No blanking, 8x8, wide glyph code
    @(negedge clk);
    g_b = 4'd5; en_b = 1; cur = -1;
    goto(1);   chk("b_first_col", int'(col_b), 'h01);
               chk("b_first_row", int'(row_b), 'h7E);
    goto(4);   chk("b_col1", int'(col_b), 'h02);
               chk("b_row1", int'(row_b), 'h09);
    goto(10);  g_b = 4'd9;
    goto(24);  chk("b_col7", int'(col_b), 'h80);
               chk("b_idx7", int'(idx_b), 7);
               chk("b_fd_before", int'(fd_b), 0);
    goto(25);  chk("b_wrap_col", int'(col_b), 'h01);
               chk("b_wrap_fd", int'(fd_b), 1);
               chk("b_glyph9", int'(ga_b), 9);
               chk("b_err_row", int'(row_b), 'h7F);
    goto(26);  chk("b_fd_after", int'(fd_b), 0);
    goto(49);  chk("b_fd2", int'(fd_b), 1);
    en_b = 0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
